// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: state encoding and requester indices shared by the arbiter
package rom_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  function automatic logic [1:0] idx_mask(logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/rom_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; a tie goes to the requester that was not granted last
module rr_pick2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  input  logic [1:0] excl,
  output logic       grant_valid,
  output logic       grant_idx
);
  logic r0, r1;
  always_comb begin
    r0 = req0 & ~excl[0];
    r1 = req1 & ~excl[1];
    grant_valid = r0 | r1;
    grant_idx = (r0 & r1) ? ~last_grant : r1;
  end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one external synchronous ROM between fetch (0) and data (1) requesters
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_enable_out,
  input  logic [DATA_W-1:0] rom_data
);
  state_t state_q, state_d;
  logic owner_q, owner_d, last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [1:0] excl;
  logic grant_valid, grant_idx, take, done;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .excl        (excl),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // The requester served in DONE sits out that cycle's arbitration
  always_comb begin
    excl = (state_q == DONE) ? idx_mask(owner_q) : 2'b00;
    take = grant_valid && (state_q == IDLE || state_q == DONE);
    state_d = (state_q == ISSUE) ? DONE : take ? ISSUE : IDLE;
    owner_d = take ? grant_idx : owner_q;
    rom_addr_d = take ? (grant_idx ? addr1 : addr0) : rom_addr_q;
    last_grant_d = (state_q == DONE) ? owner_q : last_grant_q;
    done = (state_q == DONE) && !reset;
    ack0 = done && owner_q == REQ0;
    ack1 = done && owner_q == REQ1;
    data0 = ack0 ? rom_data : '0;
    data1 = ack1 ? rom_data : '0;
    rom_enable_out = done;
    rom_addr = rom_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= REQ0;
      last_grant_q <= REQ1;
      rom_addr_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_grant_q <= last_grant_d;
      rom_addr_q <= rom_addr_d;
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: scoreboard bench; expected acks (requester, data, cycle) queued when requests are driven
module tb_rom_arbiter;
  typedef struct {
    logic       idx;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 0, reset = 1, req0 = 0, req1 = 0;
  logic [6:0] addr0 = '0, addr1 = '0, rom_addr;
  logic [7:0] data0, data1, rom_data;
  logic ack0, ack1, rom_enable_out;
  int cyc = 0, errors = 0, checks = 0;
  exp_t sb[$];
  exp_t e_m;
  logic [6:0] a0[4] = '{7'h11, 7'h22, 7'h7F, 7'h00};
  logic [6:0] a1[4] = '{7'h33, 7'h44, 7'h55, 7'h6E};

  rom_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .data0(data0), .data1(data1), .rom_addr(rom_addr),
    .rom_enable_out(rom_enable_out), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_data <= {1'b0, rom_addr} ^ 8'hA5;
  end

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(logic i, logic [6:0] a, int c);
    sb.push_back('{i, {1'b0, a} ^ 8'hA5, c});
  endtask

  always @(negedge clk) if (!reset) begin
    chk("ack_excl", {31'd0, ack0 & ack1}, 0);
    if (!ack0) chk("data0_zero", data0, 0);
    if (!ack1) chk("data1_zero", data1, 0);
    chk("en_vs_ack", rom_enable_out, ack0 | ack1);
    if (ack0 | ack1) begin
      if (sb.size() == 0) chk("unexp_ack", {ack1, ack0}, 0);
      else begin
        e_m = sb.pop_front();
        chk("ack_idx", ack1, e_m.idx);
        chk("ack_data", ack1 ? data1 : data0, e_m.data);
        chk("ack_cyc", cyc, e_m.cyc);
      end
    end
  end

  initial begin
    int c;
    tick(2);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_en", rom_enable_out, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_data", {data1, data0}, 0);
    reset = 0;
    tick(1);
    addr0 = 7'h00; req0 = 1; push(0, 7'h00, cyc + 2);
    tick(2); req0 = 0;
    tick(3);
    chk("s1_idle_en", rom_enable_out, 0);
    reset = 1; tick(1); reset = 0; tick(1);
    addr0 = 7'h01; addr1 = 7'h5A; req0 = 1; req1 = 1;
    push(0, 7'h01, cyc + 2); push(1, 7'h5A, cyc + 4);
    tick(2); req0 = 0;
    tick(2); req1 = 0;
    tick(3);
    c = cyc; addr0 = a0[0]; addr1 = a1[0];
    for (int k = 0; k < 8; k++) push(k[0], k[0] ? a1[k/2] : a0[k/2], c + 2 + 2*k);
    req0 = 1; req1 = 1;
    for (int k = 0; k < 8; k++) begin
      tick(2);
      if (!k[0]) begin
        if (k >= 6) req0 = 0; else addr0 = a0[k/2+1];
      end else begin
        if (k >= 6) req1 = 0; else addr1 = a1[k/2+1];
      end
    end
    tick(3);
    addr1 = 7'h10; req1 = 1;
    tick(1); reset = 1;
    tick(1);
    chk("s4_ack1", ack1, 0);
    chk("s4_en", rom_enable_out, 0);
    reset = 0; push(1, 7'h10, cyc + 2);
    tick(2); req1 = 0;
    tick(3);
    addr0 = 7'h33; req0 = 1;
    tick(2); reset = 1; req0 = 0; #1;
    chk("rstdone_ack", {ack1, ack0}, 0);
    chk("rstdone_en", rom_enable_out, 0);
    chk("rstdone_data", {data1, data0}, 0);
    tick(1); reset = 0;
    tick(2);
    addr0 = 7'h2C; req0 = 1; push(0, 7'h2C, cyc + 2);
    tick(1); req0 = 0;
    tick(2);
    chk("s5_en", rom_enable_out, 0);
    chk("s5_ack", ack0, 0);
    tick(2);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
